// File: rtl/iomem_pwm_leds.sv
// Memory-mapped NCH-channel PWM LED driver on the picosoc iomem bus.
// Duty values are double-buffered and only take effect at each period wrap, so outputs never glitch.
module iomem_pwm_leds #(
    parameter int          NCH     = 8,
    parameter logic [7:0]  ADDR_HI = 8'h04
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           iomem_valid,
    output logic           iomem_ready,
    input  logic [3:0]     iomem_wstrb,
    input  logic [31:0]    iomem_addr,
    input  logic [31:0]    iomem_wdata,
    output logic [31:0]    iomem_rdata,
    output logic [NCH-1:0] pwm_out,
    output logic           period_irq
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    // Handshake: a request is accepted when valid is high, the address matches
    // and ready is low; ready then pulses for exactly one cycle, with rdata loaded
    // on the same edge and held until the next accepted request.
    logic          ready_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          en_q, inv_q;
    logic [15:0]   prescale_q;
    logic [7:0]    period_q;
    logic [7:0]    duty_q   [NCH];
    logic [7:0]    shadow_q [NCH];
    logic [15:0]   pcnt_q, pcnt_d;
    logic [7:0]    count_q, count_d;
    logic          wrap_flag_q, wrap_flag_d;
    logic          irq_q, irq_d;
    logic [NCH-1:0] pwm_q, pwm_d;

    logic          sel, wr, status_rd, tick, wrap_evt;
    logic [7:0]    off;
    logic [5:0]    word;
    logic          duty_hit;
    logic [IW-1:0] didx;
    logic          unused_bits;

    assign unused_bits = ^{iomem_addr[23:8], iomem_wdata[31:16]};

    assign sel       = iomem_valid && (iomem_addr[31:24] == ADDR_HI) && !ready_q;
    assign wr        = sel && (iomem_wstrb != 4'b0000);
    assign off       = iomem_addr[7:0];
    assign word      = off[7:2];
    assign status_rd = sel && (iomem_wstrb == 4'b0000) && (off == 8'h0C);
    assign duty_hit  = (off[1:0] == 2'b00) && (word >= 6'd4) && (word < 6'(NCH + 4));
    assign didx      = IW'(word - 6'd4);

    always_comb begin
        rdata_d = rdata_q;
        if (sel) begin
            rdata_d = 32'h0;
            case (off)
                8'h00:   rdata_d = {30'h0, inv_q, en_q};
                8'h04:   rdata_d = {16'h0, prescale_q};
                8'h08:   rdata_d = {24'h0, period_q};
                8'h0C:   rdata_d = {15'h0, wrap_flag_q, count_q, 7'h0, en_q};
                default: if (duty_hit) rdata_d = {24'h0, duty_q[didx]};
            endcase
        end
    end

    assign tick     = en_q && (pcnt_q == prescale_q);
    assign wrap_evt = tick && (count_q == period_q);

    always_comb begin
        pcnt_d      = pcnt_q;
        count_d     = count_q;
        wrap_flag_d = wrap_flag_q;
        irq_d       = wrap_evt;
        if (!en_q) begin
            pcnt_d  = 16'h0;
            count_d = 8'h0;
        end else if (tick) begin
            pcnt_d  = 16'h0;
            // Counting past a lowered PERIOD rolls over through 255 back to 0.
            count_d = wrap_evt ? 8'h0 : count_q + 8'd1;
        end else begin
            pcnt_d  = pcnt_q + 16'd1;
        end
        if (status_rd) wrap_flag_d = 1'b0;
        if (wrap_evt)  wrap_flag_d = 1'b1;
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = (en_q && (count_q < shadow_q[i])) ^ inv_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0;
            en_q        <= 1'b0;
            inv_q       <= 1'b0;
            prescale_q  <= 16'h0;
            period_q    <= 8'h0;
            pcnt_q      <= 16'h0;
            count_q     <= 8'h0;
            wrap_flag_q <= 1'b0;
            irq_q       <= 1'b0;
            pwm_q       <= '0;
            for (int i = 0; i < NCH; i++) begin
                duty_q[i]   <= 8'h0;
                shadow_q[i] <= 8'h0;
            end
        end else begin
            ready_q     <= sel;
            rdata_q     <= rdata_d;
            pcnt_q      <= pcnt_d;
            count_q     <= count_d;
            wrap_flag_q <= wrap_flag_d;
            irq_q       <= irq_d;
            pwm_q       <= pwm_d;
            // Shadows sample the pre-write duty, so a write on the wrap edge waits a period.
            if (!en_q || wrap_evt) begin
                for (int i = 0; i < NCH; i++) begin
                    shadow_q[i] <= duty_q[i];
                end
            end
            if (wr) begin
                case (off)
                    8'h00: if (iomem_wstrb[0]) {inv_q, en_q} <= iomem_wdata[1:0];
                    8'h04: begin
                        if (iomem_wstrb[0]) prescale_q[7:0]  <= iomem_wdata[7:0];
                        if (iomem_wstrb[1]) prescale_q[15:8] <= iomem_wdata[15:8];
                    end
                    8'h08: if (iomem_wstrb[0]) period_q <= iomem_wdata[7:0];
                    default: if (duty_hit && iomem_wstrb[0]) duty_q[didx] <= iomem_wdata[7:0];
                endcase
            end
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign pwm_out     = pwm_q;
    assign period_irq  = irq_q;
endmodule

// File: tb/tb_iomem_pwm_leds.sv
// Directed bench for iomem_pwm_leds: bus handshake, register map, PWM waveform,
// double buffering, prescaling, STATUS wrap flag and asynchronous reset.
module tb_iomem_pwm_leds;
    localparam int          NCH  = 8;
    localparam logic [31:0] BASE = 32'h0400_0000;

    logic           clk;
    logic           resetn;
    logic           iomem_valid;
    logic           iomem_ready;
    logic [3:0]     iomem_wstrb;
    logic [31:0]    iomem_addr;
    logic [31:0]    iomem_wdata;
    logic [31:0]    iomem_rdata;
    logic [NCH-1:0] pwm_out;
    logic           period_irq;

    int checks = 0;
    int errors = 0;

    iomem_pwm_leds #(.NCH(NCH), .ADDR_HI(8'h04)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .pwm_out     (pwm_out),
        .period_irq  (period_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus transaction; checks ready is low before, high one cycle after valid, then low.
    task automatic bus(input logic [3:0] ws, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
        @(negedge clk);
        chk("ready_idle", {31'h0, iomem_ready}, 32'h0);
        iomem_valid = 1'b1;
        iomem_wstrb = ws;
        iomem_addr  = a;
        iomem_wdata = wd;
        @(posedge clk);
        #1;
        chk("ready_pulse", {31'h0, iomem_ready}, 32'h1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        chk("ready_drop", {31'h0, iomem_ready}, 32'h0);
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] ws);
        logic [31:0] dummy;
        bus(ws, BASE | {24'h0, o}, d, dummy);
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus(4'h0, a, 32'h0, r);
        chk(tag, r, exp);
    endtask

    task automatic wait_irq(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (period_irq) seen = 1'b1;
        end
        chk(tag, {31'h0, seen}, 32'h1);
    endtask

    initial begin
        int   hi0, hi1, hi2, nirq;
        logic bad;

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, iomem_ready}, 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        chk("rst_pwm",   {24'h0, pwm_out}, 32'h0);
        chk("rst_irq",   {31'h0, period_irq}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        rd_exp("rst_ctrl",     BASE | 32'h00, 32'h0);
        rd_exp("rst_prescale", BASE | 32'h04, 32'h0);
        rd_exp("rst_period",   BASE | 32'h08, 32'h0);
        rd_exp("rst_status",   BASE | 32'h0C, 32'h0);
        for (int i = 0; i < NCH; i++) begin
            rd_exp($sformatf("rst_duty%0d", i), BASE | (32'h10 + 32'(4 * i)), 32'h0);
        end

        // Byte-lane writes, address aliasing and unmapped offsets.
        wr(8'h00, 32'h0000_0003, 4'b0001);
        rd_exp("ctrl_alias", BASE | 32'h00AB_CD00, 32'h3);
        wr(8'h00, 32'h0000_0002, 4'b0001);
        @(negedge clk);
        chk("inv_disabled_high", {24'h0, pwm_out}, 32'h0000_00FF);
        wr(8'h00, 32'h0, 4'b0001);
        @(negedge clk);
        chk("inv_off_low", {24'h0, pwm_out}, 32'h0);
        wr(8'h04, 32'hFFFF_FFFF, 4'b0010);
        rd_exp("prescale_lane1", BASE | 32'h04, 32'h0000_FF00);
        wr(8'h40, 32'hFFFF_FFFF, 4'b1111);
        rd_exp("unmapped_40", BASE | 32'h40, 32'h0);
        rd_exp("unmapped_duty8", BASE | 32'h30, 32'h0);

        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0500_0000;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (iomem_ready) bad = 1'b1;
        end
        iomem_valid = 1'b0;
        chk("foreign_no_ready", {31'h0, bad}, 32'h0);

        // Waveform: PRESCALE=0, PERIOD=9, duties 3/0/10.
        wr(8'h04, 32'h0, 4'b1111);
        wr(8'h08, 32'd9, 4'b0001);
        wr(8'h10, 32'd3, 4'b0001);
        wr(8'h14, 32'd0, 4'b0001);
        wr(8'h18, 32'd10, 4'b0001);
        wr(8'h00, 32'h1, 4'b0001);
        hi0 = 0; hi1 = 0; hi2 = 0; nirq = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pwm_out[0]) hi0++;
            if (pwm_out[1]) hi1++;
            if (pwm_out[2]) hi2++;
            if (period_irq) nirq++;
        end
        chk("wave_ch0_hi", 32'(hi0), 32'd6);
        chk("wave_ch1_hi", 32'(hi1), 32'd0);
        chk("wave_ch2_hi", 32'(hi2), 32'd20);
        chk("wave_irqs",   32'(nirq), 32'd2);

        // Mid-period duty write only takes effect after the next wrap.
        wait_irq("db_wrap_seen");
        hi0 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (pwm_out[0]) hi0++;
            if (k == 2) begin
                iomem_valid = 1'b1;
                iomem_wstrb = 4'b0001;
                iomem_addr  = BASE | 32'h10;
                iomem_wdata = 32'd7;
            end
            if (k == 3) begin
                iomem_valid = 1'b0;
                iomem_wstrb = 4'h0;
            end
        end
        chk("db_cur_period", 32'(hi0), 32'd3);
        chk("db_wrap_irq", {31'h0, period_irq}, 32'h1);
        hi0 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pwm_out[0]) hi0++;
        end
        chk("db_next_period", 32'(hi0), 32'd7);
        rd_exp("db_pending_rd", BASE | 32'h10, 32'd7);

        // STATUS wrap flag: set by earlier wraps, cleared by read, write ignored.
        wr(8'h00, 32'h0, 4'b0001);
        rd_exp("status_wrap_set", BASE | 32'h0C, 32'h0001_0000);
        rd_exp("status_cleared",  BASE | 32'h0C, 32'h0);
        wr(8'h0C, 32'hFFFF_FFFF, 4'b1111);
        rd_exp("status_ro", BASE | 32'h0C, 32'h0);

        // Prescale: tick every 4 clks, PERIOD=1 -> wrap every 8 clks.
        wr(8'h04, 32'd3, 4'b1111);
        wr(8'h08, 32'd1, 4'b0001);
        wr(8'h10, 32'd1, 4'b0001);
        wr(8'h00, 32'h1, 4'b0001);
        wait_irq("ps_wrap_seen");
        hi0 = 0; hi2 = 0; nirq = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (pwm_out[0]) hi0++;
            if (pwm_out[2]) hi2++;
            if (period_irq) nirq++;
        end
        chk("ps_ch0_hi", 32'(hi0), 32'd8);
        chk("ps_ch2_hi", 32'(hi2), 32'd16);
        chk("ps_irqs",   32'(nirq), 32'd2);
        begin
            logic [31:0] st;
            bus(4'h0, BASE | 32'h0C, 32'h0, st);
            chk("ps_status_en_wrap", st & 32'h0001_0001, 32'h0001_0001);
        end

        // Asynchronous reset with count=5, ready high and ch0 high.
        wr(8'h00, 32'h0, 4'b0001);
        wr(8'h04, 32'h0, 4'b1111);
        wr(8'h08, 32'd9, 4'b0001);
        wr(8'h10, 32'd7, 4'b0001);
        wr(8'h00, 32'h1, 4'b0001);
        wait_irq("ar_wrap_seen");
        repeat (4) @(negedge clk);
        iomem_valid = 1'b1;
        iomem_wstrb = 4'h0;
        iomem_addr  = BASE | 32'h00;
        @(negedge clk);
        chk("ar_pre_ready", {31'h0, iomem_ready}, 32'h1);
        chk("ar_pre_pwm0",  {31'h0, pwm_out[0]}, 32'h1);
        resetn = 1'b0;
        #1;
        chk("ar_pwm",   {24'h0, pwm_out}, 32'h0);
        chk("ar_ready", {31'h0, iomem_ready}, 32'h0);
        chk("ar_irq",   {31'h0, period_irq}, 32'h0);
        chk("ar_rdata", iomem_rdata, 32'h0);
        iomem_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pwm_out != '0 || period_irq) bad = 1'b1;
        end
        chk("ar_stays_idle", {31'h0, bad}, 32'h0);
        rd_exp("ar_ctrl",   BASE | 32'h00, 32'h0);
        rd_exp("ar_status", BASE | 32'h0C, 32'h0);
        rd_exp("ar_duty0",  BASE | 32'h10, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
